// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and types for the fetch queue and address checks
package fetch_queue_pkg;

    typedef logic [4:0] exc_t;

    localparam exc_t        EXC_NONE         = 5'd0;
    localparam exc_t        EXC_ADEL         = 5'd4;
    localparam logic [31:0] TEXT_LO_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI_DEFAULT  = 32'h0000_6FFC;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - F-side push and D-side head signals of the fetch queue
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic [31:0] Pc_F;
    logic [31:0] Instr_F;
    logic        Push_F;
    logic        Ready_F;
    logic        Pop_D;
    logic        Flush;
    logic        Valid_D;
    logic [31:0] Pc_D;
    logic [31:0] Instr_D;
    exc_t        ExcCode_D;

    modport master (
        output Pc_F, Instr_F, Push_F, Pop_D, Flush,
        input  Ready_F, Valid_D, Pc_D, Instr_D, ExcCode_D
    );

    modport slave (
        input  Pc_F, Instr_F, Push_F, Pop_D, Flush,
        output Ready_F, Valid_D, Pc_D, Instr_D, ExcCode_D
    );

endinterface

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - combinational AdEL detector: misaligned or outside the text segment
module fetch_addr_check
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] TEXT_LO = TEXT_LO_DEFAULT,
    parameter logic [31:0] TEXT_HI = TEXT_HI_DEFAULT
) (
    input  logic [31:0] addr,
    output logic        adel
);

    assign adel = (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch FIFO between F and D; optional FETCH_QUEUE_STAT_EN adds Fetch_Cnt/Flush_Cnt
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] TEXT_LO  = TEXT_LO_DEFAULT,
    parameter logic [31:0] TEXT_HI  = TEXT_HI_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
`ifdef FETCH_QUEUE_STAT_EN
    output logic [31:0]  Fetch_Cnt,
    output logic [31:0]  Flush_Cnt,
`endif
    fetch_queue_if.slave fq
);

    localparam int unsigned    PW       = $clog2(DEPTH);
    localparam int unsigned    CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [31:0]   slotPc    [DEPTH];
    logic [31:0]   slotInstr [DEPTH];
    logic          slotAdel  [DEPTH];
    logic [PW-1:0] rd;
    logic [PW-1:0] wr;
    logic [CW-1:0] count;

    logic pushAdel;
    logic pushOk;
    logic popOk;

    fetch_addr_check #(
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) u_addr_check (
        .addr (fq.Pc_F),
        .adel (pushAdel)
    );

    // Ready depends only on registered count, so En_Pc has no path from the D-stage stall
    assign fq.Ready_F = (count != FULL_CNT);
    assign fq.Valid_D = (count != '0);

    assign pushOk = fq.Push_F && fq.Ready_F && !fq.Flush;
    assign popOk  = fq.Pop_D && fq.Valid_D && !fq.Flush;

    assign fq.Pc_D      = slotPc[rd];
    assign fq.Instr_D   = fq.Valid_D ? slotInstr[rd] : 32'h0;
    assign fq.ExcCode_D = (fq.Valid_D && slotAdel[rd]) ? EXC_ADEL : EXC_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slotPc[i]    <= PC_RESET;
                slotInstr[i] <= '0;
                slotAdel[i]  <= 1'b0;
            end
        end else if (fq.Flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                slotPc[wr]    <= fq.Pc_F;
                slotInstr[wr] <= pushAdel ? 32'h0 : fq.Instr_F;
                slotAdel[wr]  <= pushAdel;
                wr            <= wr + 1'b1;
            end
            if (popOk) begin
                rd <= rd + 1'b1;
            end
            if (pushOk && !popOk) begin
                count <= count + 1'b1;
            end else if (popOk && !pushOk) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FETCH_QUEUE_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            Fetch_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (pushOk) begin
                Fetch_Cnt <= Fetch_Cnt + 32'd1;
            end
            if (fq.Flush) begin
                Flush_Cnt <= Flush_Cnt + 32'(count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
`ifdef FETCH_QUEUE_STAT_EN
    logic [31:0] Fetch_Cnt;
    logic [31:0] Flush_Cnt;
`endif

    fetch_queue_if fq ();

    fetch_queue #(
        .DEPTH    (2),
        .PC_RESET (32'h0000_3000),
        .TEXT_LO  (32'h0000_3000),
        .TEXT_HI  (32'h0000_6FFC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FETCH_QUEUE_STAT_EN
        .Fetch_Cnt (Fetch_Cnt),
        .Flush_Cnt (Flush_Cnt),
`endif
        .fq        (fq)
    );

    always #5 clk = ~clk;

    // observed = {Valid_D, Ready_F, ExcCode_D, Pc_D, Instr_D}
    logic [70:0] obs;
    assign obs = {fq.Valid_D, fq.Ready_F, fq.ExcCode_D, fq.Pc_D, fq.Instr_D};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic [31:0] pc, input logic [31:0] instr,
                         input logic pop, input logic flush);
        fq.Push_F  = push;
        fq.Pc_F    = pc;
        fq.Instr_F = instr;
        fq.Pop_D   = pop;
        fq.Flush   = flush;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h0000_3000, 32'h0})
            begin bad++; $display("FAIL reset_state got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h0000_3000, 32'h0}); end
    endtask

    task automatic test_fill();
        drive(1'b1, 32'h3000, 32'h1111_1111, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3000, 32'h1111_1111})
            begin bad++; $display("FAIL fill_one got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3000, 32'h1111_1111}); end
        drive(1'b1, 32'h3004, 32'h2222_2222, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b0, 5'd0, 32'h3000, 32'h1111_1111})
            begin bad++; $display("FAIL fill_full got=%h want=%h", obs, {1'b1, 1'b0, 5'd0, 32'h3000, 32'h1111_1111}); end
        drive(1'b1, 32'h3008, 32'h3333_3333, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b0, 5'd0, 32'h3000, 32'h1111_1111})
            begin bad++; $display("FAIL fill_refused got=%h want=%h", obs, {1'b1, 1'b0, 5'd0, 32'h3000, 32'h1111_1111}); end
    endtask

    task automatic test_full_pop_push();
        drive(1'b1, 32'h3008, 32'h3333_3333, 1'b1, 1'b0);
        #1;
        total++;
        if (fq.Ready_F !== 1'b0)
            begin bad++; $display("FAIL full_ready_pre got=%b want=0", fq.Ready_F); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3004, 32'h2222_2222})
            begin bad++; $display("FAIL full_pop got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3004, 32'h2222_2222}); end
    endtask

    task automatic test_simul_wrap();
        drive(1'b1, 32'h300C, 32'h4444_4444, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h300C, 32'h4444_4444})
            begin bad++; $display("FAIL simul_push_pop got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h300C, 32'h4444_4444}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h3004, 32'h0})
            begin bad++; $display("FAIL drain_empty got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h3004, 32'h0}); end
        step();
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h3004, 32'h0})
            begin bad++; $display("FAIL empty_pop got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h3004, 32'h0}); end
        drive(1'b1, 32'h3014, 32'h5555_5555, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3014, 32'h5555_5555})
            begin bad++; $display("FAIL push_after_empty got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3014, 32'h5555_5555}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h300C, 32'h0})
            begin bad++; $display("FAIL wrap_empty got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h300C, 32'h0}); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h3018, 32'hAAAA_0018, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h301C, 32'hAAAA_001C, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h4000, 32'hBBBB_4000, 1'b0, 1'b1);
        step();
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h3018, 32'h0})
            begin bad++; $display("FAIL flush_full got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h3018, 32'h0}); end
        drive(1'b1, 32'h3020, 32'hAAAA_0020, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h4000, 32'hBBBB_4000, 1'b1, 1'b1);
        step();
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h3020, 32'h0})
            begin bad++; $display("FAIL flush_push got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h3020, 32'h0}); end
        drive(1'b1, 32'h3024, 32'hAAAA_0024, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3024, 32'hAAAA_0024})
            begin bad++; $display("FAIL post_flush_head got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3024, 32'hAAAA_0024}); end
        drive(1'b1, 32'h3028, 32'hAAAA_0028, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3028, 32'hAAAA_0028})
            begin bad++; $display("FAIL post_flush_next got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3028, 32'hAAAA_0028}); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (fq.Valid_D !== 1'b0)
            begin bad++; $display("FAIL post_flush_drain got=%b want=0", fq.Valid_D); end
`ifdef FETCH_QUEUE_STAT_EN
        total++;
        if (Fetch_Cnt !== 32'd9)
            begin bad++; $display("FAIL fetch_cnt got=%0d want=9", Fetch_Cnt); end
        total++;
        if (Flush_Cnt !== 32'd3)
            begin bad++; $display("FAIL flush_cnt got=%0d want=3", Flush_Cnt); end
`endif
    endtask

    task automatic test_adel();
        drive(1'b1, 32'h3002, 32'h6666_6666, 1'b0, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd4, 32'h3002, 32'h0})
            begin bad++; $display("FAIL adel_misalign got=%h want=%h", obs, {1'b1, 1'b1, 5'd4, 32'h3002, 32'h0}); end
        drive(1'b1, 32'h7000, 32'h7777_7777, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd4, 32'h7000, 32'h0})
            begin bad++; $display("FAIL adel_above got=%h want=%h", obs, {1'b1, 1'b1, 5'd4, 32'h7000, 32'h0}); end
        drive(1'b1, 32'h3010, 32'h8888_8888, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h3010, 32'h8888_8888})
            begin bad++; $display("FAIL adel_legal got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h3010, 32'h8888_8888}); end
        drive(1'b1, 32'h6FFC, 32'h9999_9999, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd0, 32'h6FFC, 32'h9999_9999})
            begin bad++; $display("FAIL adel_top_edge got=%h want=%h", obs, {1'b1, 1'b1, 5'd0, 32'h6FFC, 32'h9999_9999}); end
        drive(1'b1, 32'h2FFC, 32'hCCCC_CCCC, 1'b1, 1'b0);
        step();
        total++;
        if (obs !== {1'b1, 1'b1, 5'd4, 32'h2FFC, 32'h0})
            begin bad++; $display("FAIL adel_below got=%h want=%h", obs, {1'b1, 1'b1, 5'd4, 32'h2FFC, 32'h0}); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (fq.ExcCode_D !== EXC_NONE || fq.Valid_D !== 1'b0)
            begin bad++; $display("FAIL adel_drain got=%b/%0d want=0/0", fq.Valid_D, fq.ExcCode_D); end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 32'h3030, 32'hDDDD_3030, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h3034, 32'hDDDD_3034, 1'b0, 1'b0);
        step();
        total++;
        if (fq.Ready_F !== 1'b0)
            begin bad++; $display("FAIL pre_reset_full got=%b want=0", fq.Ready_F); end
        reset = 1'b1;
        drive(1'b1, 32'h3038, 32'hDDDD_3038, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 32'h3000, 32'h0})
            begin bad++; $display("FAIL midstream_reset got=%h want=%h", obs, {1'b0, 1'b1, 5'd0, 32'h3000, 32'h0}); end
`ifdef FETCH_QUEUE_STAT_EN
        total++;
        if (Fetch_Cnt !== 32'd0 || Flush_Cnt !== 32'd0)
            begin bad++; $display("FAIL stat_reset got=%0d/%0d want=0/0", Fetch_Cnt, Flush_Cnt); end
`endif
    endtask

    initial begin
        clk   = 1'b0;
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_full_pop_push();
        test_simul_wrap();
        test_flush();
        test_adel();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
